// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, default widths and parity helper for data_mem_ctrl
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - DEPTH x WIDTH storage, one sync write port, one registered read port with write-first bypass
module mem_array #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata only moves on a read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data memory controller with post-reset clear; optional parity via DATA_MEM_PARITY_EN
import mem_pkg::*;

module data_mem_ctrl #(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DEPTH     = 2 ** ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataSrc,
`ifdef DATA_MEM_PARITY_EN
    input  logic              ParityInject,
`endif
    output logic              Ready,
    output logic              RdValid,
    output logic [DATA_W-1:0] DataMemOut,
    output logic              AddrErr,
    output logic              ParityErr
);

`ifdef DATA_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
    localparam logic [MEM_W-1:0] CLEAR_WORD = {even_parity(64'(CLEAR_VAL)), CLEAR_VAL};
`else
    localparam int MEM_W = DATA_W;
    localparam logic [MEM_W-1:0] CLEAR_WORD = CLEAR_VAL;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic              in_range;
    logic              acc_rd;
    logic              acc_wr;
    logic              oor_q;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [MEM_W-1:0]  arr_wdata;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rdata;

    assign clr_last = (clr_cnt == LAST_ADDR);
    assign in_range = ({1'b0, Address} < DEPTH_X);
    assign acc_rd   = Ready && !Reset && MemRead;
    assign acc_wr   = Ready && !Reset && MemWrite;

`ifdef DATA_MEM_PARITY_EN
    assign wr_word = {even_parity(64'(DataSrc)) ^ ParityInject, DataSrc};
`else
    assign wr_word = DataSrc;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_last) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        Ready = (state == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            clr_cnt <= '0;
        end else if (state == CLEAR && !clr_last) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // The clear sweep owns the write port; requests cannot be accepted then.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = Address;
        arr_wdata = wr_word;
        if (!Reset) begin
            if (state == CLEAR) begin
                arr_we    = 1'b1;
                arr_waddr = clr_cnt;
                arr_wdata = CLEAR_WORD;
            end else if (acc_wr && in_range) begin
                arr_we = 1'b1;
            end
        end
    end

    mem_array #(
        .WIDTH  (MEM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (CLK),
        .rst   (Reset),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (acc_rd && in_range),
        .raddr (Address),
        .rdata (rdata)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            RdValid <= 1'b0;
            AddrErr <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            RdValid <= acc_rd;
            AddrErr <= (acc_rd || acc_wr) && !in_range;
            if (acc_rd) begin
                oor_q <= !in_range;
            end
        end
    end

    assign DataMemOut = oor_q ? '0 : rdata[DATA_W-1:0];

`ifdef DATA_MEM_PARITY_EN
    assign ParityErr = RdValid && !oor_q &&
                       (even_parity(64'(rdata[DATA_W-1:0])) != rdata[DATA_W]);
`else
    assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl (default and DEPTH=200 instances)
module tb_data_mem_ctrl;

    logic       CLK;
    logic       Reset;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] Address;
    logic [7:0] DataSrc;
`ifdef DATA_MEM_PARITY_EN
    logic       ParityInject;
`endif

    logic       a_ready, a_rdvalid, a_addr_err, a_par_err;
    logic [7:0] a_dout;
    logic       s_ready, s_rdvalid, s_addr_err, s_par_err;
    logic [7:0] s_dout;

    int checks   = 0;
    int failures = 0;
    int n;
    int ns;
    int spurious;

    data_mem_ctrl dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Address      (Address),
        .DataSrc      (DataSrc),
`ifdef DATA_MEM_PARITY_EN
        .ParityInject (ParityInject),
`endif
        .Ready        (a_ready),
        .RdValid      (a_rdvalid),
        .DataMemOut   (a_dout),
        .AddrErr      (a_addr_err),
        .ParityErr    (a_par_err)
    );

    data_mem_ctrl #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .DEPTH     (200),
        .CLEAR_VAL (8'h5A)
    ) dut_s (
        .CLK          (CLK),
        .Reset        (Reset),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Address      (Address),
        .DataSrc      (DataSrc),
`ifdef DATA_MEM_PARITY_EN
        .ParityInject (ParityInject),
`endif
        .Ready        (s_ready),
        .RdValid      (s_rdvalid),
        .DataMemOut   (s_dout),
        .AddrErr      (s_addr_err),
        .ParityErr    (s_par_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        Address  = a;
        DataSrc  = d;
        MemWrite = 1'b1;
        step();
        MemWrite = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a);
        Address = a;
        MemRead = 1'b1;
        step();
        MemRead = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Address  = '0;
        DataSrc  = '0;
`ifdef DATA_MEM_PARITY_EN
        ParityInject = 1'b0;
`endif
        step();
        step();
        check("rst_ready",   32'(a_ready),    0);
        check("rst_rdvalid", 32'(a_rdvalid),  0);
        check("rst_addrerr", 32'(a_addr_err), 0);
        check("rst_parerr",  32'(a_par_err),  0);
        check("rst_dout",    32'(a_dout),     0);
        check("rst_ready_s", 32'(s_ready),    0);

        // Clear sweep length
        Reset = 1'b0;
        n  = 0;
        ns = 0;
        while (!a_ready && n < 400) begin
            step();
            n++;
            if (s_ready && ns == 0) ns = n;
        end
        check("clear_cycles",   n,  256);
        check("clear_cycles_s", ns, 200);

        do_read(8'd0);
        check("rd0_valid", 32'(a_rdvalid), 1);
        check("rd0_data",  32'(a_dout),    'h00);
        check("rd0_data_s", 32'(s_dout),   'h5A);
        do_read(8'd127);
        check("rd127_data", 32'(a_dout),   'h00);
        check("rd127_valid", 32'(a_rdvalid), 1);
        do_read(8'd255);
        check("rd255_data", 32'(a_dout),   'h00);
        check("rd255_valid", 32'(a_rdvalid), 1);
        check("rd255_addrerr_s", 32'(s_addr_err), 1);
        check("rd255_valid_s", 32'(s_rdvalid), 1);
        step();
        check("rdvalid_pulse", 32'(a_rdvalid), 0);
        check("addrerr_pulse_s", 32'(s_addr_err), 0);

        // Write then read next cycle
        do_write(8'h10, 8'hA5);
        do_read(8'h10);
        check("wr_rd_data",  32'(a_dout),    'hA5);
        check("wr_rd_valid", 32'(a_rdvalid), 1);
        check("wr_rd_data_s", 32'(s_dout),   'hA5);
        check("wr_rd_parerr", 32'(a_par_err), 0);

        // Same-cycle read and write: write-first
        Address  = 8'h20;
        DataSrc  = 8'h3C;
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        step();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        check("wfirst_data",  32'(a_dout),    'h3C);
        check("wfirst_valid", 32'(a_rdvalid), 1);

        // Back-to-back reads, then hold
        Address = 8'h10;
        MemRead = 1'b1;
        step();
        check("b2b_0_data", 32'(a_dout), 'hA5);
        Address = 8'h20;
        step();
        MemRead = 1'b0;
        check("b2b_1_data",  32'(a_dout),    'h3C);
        check("b2b_1_valid", 32'(a_rdvalid), 1);
        step();
        check("hold_data",  32'(a_dout),    'h3C);
        check("hold_valid", 32'(a_rdvalid), 0);

        // Out-of-range on the DEPTH=200 instance
        do_write(8'd201, 8'h77);
        check("oor_wr_addrerr_s", 32'(s_addr_err), 1);
        check("oor_wr_addrerr",   32'(a_addr_err), 0);
        do_read(8'd201);
        check("oor_rd_addrerr_s", 32'(s_addr_err), 1);
        check("oor_rd_data_s",    32'(s_dout),     'h00);
        check("oor_rd_valid_s",   32'(s_rdvalid),  1);
        check("oor_rd_parerr_s",  32'(s_par_err),  0);
        check("inr_rd_data",      32'(a_dout),     'h77);
        do_read(8'd0);
        check("oor_rd0_data_s",    32'(s_dout),     'h5A);
        check("oor_rd0_addrerr_s", 32'(s_addr_err), 0);
        do_write(8'd199, 8'h42);
        check("edge_wr_addrerr_s", 32'(s_addr_err), 0);
        do_read(8'd199);
        check("edge_rd_data_s", 32'(s_dout), 'h42);
        do_read(8'd200);
        check("depth_rd_addrerr_s", 32'(s_addr_err), 1);
        check("depth_rd_data_s",    32'(s_dout),     'h00);

`ifdef DATA_MEM_PARITY_EN
        ParityInject = 1'b1;
        do_write(8'd5, 8'h0F);
        ParityInject = 1'b0;
        do_read(8'd5);
        check("par_inj_err",   32'(a_par_err), 1);
        check("par_inj_valid", 32'(a_rdvalid), 1);
        do_write(8'd5, 8'h0F);
        do_read(8'd5);
        check("par_ok_err",  32'(a_par_err), 0);
        check("par_ok_data", 32'(a_dout),    'h0F);
        ParityInject = 1'b1;
        do_write(8'd201, 8'h01);
        ParityInject = 1'b0;
        do_read(8'd201);
        check("par_oor_err_s", 32'(s_par_err), 0);
`endif

        // Reset in the middle of the sweep restarts it
        Reset = 1'b1;
        step();
        Reset    = 1'b0;
        n        = 0;
        spurious = 0;
        while (n < 100) begin
            step();
            n++;
        end
        check("midclear_ready", 32'(a_ready), 0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n = 0;
        while (!a_ready && n < 400) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            if (n == 150) begin
                Address  = 8'd5;
                DataSrc  = 8'h99;
                MemWrite = 1'b1;
                MemRead  = 1'b1;
            end else if (n == 151) begin
                Address = 8'd250;
                MemRead = 1'b1;
            end
            step();
            n++;
            if (a_rdvalid || a_addr_err || s_rdvalid || s_addr_err) spurious++;
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        check("restart_clear_cycles", n, 256);
        check("clear_no_response", spurious, 0);
        do_read(8'd5);
        check("clear_wr_ignored",   32'(a_dout),    'h00);
        check("clear_wr_ignored_s", 32'(s_dout),    'h5A);
        check("post_clear_valid",   32'(a_rdvalid), 1);
        do_read(8'h10);
        check("post_clear_rewiped", 32'(a_dout), 'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised successor to the processor's data memory. Wraps a synchronous-write, registered-read RAM of DEPTH words × DATA_W bits behind a request/valid handshake. Adds a post-reset hardware clear sequence, write-first read-during-write behaviour and optional per-word parity. Sits between the datapath load/store stage and the memory array; the stall logic consumes `Ready` and `RdValid`.

## Interface
- DATA_W, 8: word width in bits.
- ADDR_W, 8: address width in bits.
- DEPTH, 2**ADDR_W: number of words; must be ≤ 2**ADDR_W.
- CLEAR_VAL, '0: value written to every word during the clear sequence.

Ports:
- CLK  input  1  clock; all state changes on the posedge.
- Reset  input  1  synchronous, active-high reset.
- MemRead  input  1  read request, accepted only when Ready=1.
- MemWrite  input  1  write request, accepted only when Ready=1.
- Address  input  ADDR_W  word address for the request.
- DataSrc  input  DATA_W  write data.
- Ready  output  1  high when requests are accepted (state IDLE).
- RdValid  output  1  one-cycle pulse: DataMemOut holds the result of the read accepted in the previous cycle.
- DataMemOut  output  DATA_W  registered read data; holds its value between reads.
- AddrErr  output  1  one-cycle pulse the cycle after an accepted request with Address ≥ DEPTH.
- ParityErr  output  1  present only with DATA_MEM_PARITY_EN (see Configuration).

## Operation
- FSM states:
  - CLEAR: a counter walks addresses 0..DEPTH-1, writing CLEAR_VAL one word per cycle. Ready=0. On count DEPTH-1 → IDLE.
  - IDLE: Ready=1; requests are serviced.
- Reset puts the FSM in CLEAR with counter=0, from any state. A reset during CLEAR restarts the sweep at 0.
- Reset values: Ready=0, RdValid=0, AddrErr=0, ParityErr=0, DataMemOut='0.
- Write (IDLE, MemWrite=1, Address<DEPTH): mem[Address] ← DataSrc at the posedge.
- Read (IDLE, MemRead=1, Address<DEPTH): the next cycle has DataMemOut=mem[Address] and RdValid=1.
- MemRead and MemWrite together at the same address: write-first. DataMemOut returns DataSrc.
- Address ≥ DEPTH:
  - A write is dropped; memory is unchanged.
  - A read yields DataMemOut='0 with RdValid=1.
  - AddrErr pulses in both cases.
- Requests presented while Ready=0 are ignored: no write, no RdValid, no AddrErr. Callers must hold the request until Ready.
- Back-to-back reads are supported, one per cycle, with full throughput.

## Timing
- Write latency: 0. Data is visible to a read issued in the following cycle, and to a same-cycle read via write-first.
- Read latency: exactly 1 cycle from acceptance to RdValid.
- Clear duration: DEPTH cycles after the cycle in which Reset is sampled low. Ready rises on cycle DEPTH+1.
- No combinational path from any input to any output; all outputs are registers or decodes of FSM state.

## Configuration
- `DATA_MEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit computed from DataSrc (CLEAR_VAL during clear).
  - An extra input, `ParityInject input 1`, inverts the stored parity bit on an accepted write.
  - On each RdValid, ParityErr=1 if the recomputed parity mismatches the stored bit.
  - Out-of-range reads never flag ParityErr.
- Not defined:
  - No parity storage.
  - The ParityInject port is absent.
  - ParityErr is tied to 0.

## Structure
- Package `mem_pkg`: FSM state enum (CLEAR, IDLE), default widths, and the parity function.
- Sub-module `mem_array`: plain DEPTH × (DATA_W[+1]) storage with one synchronous write port and one registered read port, with write-first bypass. `data_mem_ctrl` holds the FSM, clear counter, range check, handshake and parity logic.

## Test plan
- Reset, then idle. Expected: Ready=0 for exactly DEPTH cycles (256 at defaults). Afterwards, reads of addresses 0, 127 and 255 return CLEAR_VAL with RdValid pulsing.
- Write 0xA5 to address 0x10, then read 0x10 the next cycle. Expected: DataMemOut=0xA5 with RdValid=1, one cycle after the read.
- Same-cycle MemRead+MemWrite to 0x20 with DataSrc=0x3C, where the old value is 0x00. Expected: the next cycle gives DataMemOut=0x3C.
- DEPTH=200, ADDR_W=8; write 0x77 to 201, then read 201. Expected:
  - AddrErr pulses twice.
  - The read returns 0x00.
  - A read of address 0 still returns CLEAR_VAL.
- Assert Reset at clear count 100, then release. Expected: Ready stays 0 for a full DEPTH cycles. A write issued during the clear is ignored (a read after the clear returns CLEAR_VAL).
- With DATA_MEM_PARITY_EN: write 0x0F with ParityInject=1 to address 5, then read 5. Expected: ParityErr=1 alongside RdValid. A rewrite with ParityInject=0 followed by a read gives ParityErr=0.
